// File: rtl/crypto_mem_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : crypto_mem_initiator_if
//  Purpose  : Control, memory-port-2 and cipher-core handshake bundle for
//             crypto_mem_initiator. master = initiator view, slave = peers.
//  Revision : 1.0  initial release
// ============================================================================
interface crypto_mem_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              START;
  logic [ADDR_W-1:0] SRC_ADDR;
  logic [ADDR_W-1:0] DST_ADDR;
  logic [LEN_W-1:0]  LEN;
  logic              BUSY;
  logic              DONE;
  logic              ERROR;
  logic [ADDR_W-1:0] MEM_ADDR2;
  logic [31:0]       MEM_DIN2;
  logic              MEM_READ2;
  logic              MEM_WRITE2;
  logic [1:0]        MEM_SIZE;
  logic              MEM_SIGN;
  logic [31:0]       MEM_DOUT2;
  logic [31:0]       TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [31:0]       RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;

  modport master (
    input  START, SRC_ADDR, DST_ADDR, LEN, MEM_DOUT2, TX_READY, RX_DATA, RX_VALID,
    output BUSY, DONE, ERROR, MEM_ADDR2, MEM_DIN2, MEM_READ2, MEM_WRITE2,
           MEM_SIZE, MEM_SIGN, TX_DATA, TX_VALID, RX_READY
  );

  modport slave (
    output START, SRC_ADDR, DST_ADDR, LEN, MEM_DOUT2, TX_READY, RX_DATA, RX_VALID,
    input  BUSY, DONE, ERROR, MEM_ADDR2, MEM_DIN2, MEM_READ2, MEM_WRITE2,
           MEM_SIZE, MEM_SIGN, TX_DATA, TX_VALID, RX_READY
  );
endinterface
`default_nettype wire

// File: rtl/crypto_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : crypto_mem_initiator
//  Purpose  : Reads a block of words from data-memory port 2, streams each
//             through the cipher core and writes the result to a destination.
//             Optional macro CRYPTO_MEM_BSWAP_EN byte-reverses words at the
//             core boundary so the core sees big-endian data.
//  Revision : 1.0  initial release
// ============================================================================
module crypto_mem_initiator #(
  parameter int                ADDR_W  = 32,
  parameter int                LEN_W   = 16,
  parameter logic [ADDR_W-1:0] MEM_TOP = 32'h0001_0000
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  crypto_mem_initiator_if.master bus
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_check   = 3'd1;
  localparam logic [2:0] c_st_rd_req  = 3'd2;
  localparam logic [2:0] c_st_rd_wait = 3'd3;
  localparam logic [2:0] c_st_send    = 3'd4;
  localparam logic [2:0] c_st_recv    = 3'd5;
  localparam logic [2:0] c_st_wr      = 3'd6;
  localparam logic [2:0] c_st_finish  = 3'd7;

  localparam int c_pad_w = ADDR_W + 1 - (LEN_W + 2);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_din;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [31:0]       r_tx_data;
  logic              r_tx_valid;
  logic              r_rx_ready;

  logic [ADDR_W:0]   w_len_bytes;
  logic [ADDR_W:0]   w_src_end;
  logic [ADDR_W:0]   w_dst_end;
  logic [ADDR_W:0]   w_top;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_wr_word;

  // One extra bit keeps addr + 4*LEN from wrapping during the range check
  assign w_len_bytes    = {{c_pad_w{1'b0}}, r_remaining, 2'b00};
  assign w_src_end      = {1'b0, r_src_ptr} + w_len_bytes;
  assign w_dst_end      = {1'b0, r_dst_ptr} + w_len_bytes;
  assign w_top          = {1'b0, MEM_TOP};
  assign w_misaligned   = (r_src_ptr[1:0] != 2'b00) || (r_dst_ptr[1:0] != 2'b00);
  assign w_out_of_range = (w_src_end > w_top) || (w_dst_end > w_top);

`ifdef CRYPTO_MEM_BSWAP_EN
  assign w_rd_word = {bus.MEM_DOUT2[7:0], bus.MEM_DOUT2[15:8],
                      bus.MEM_DOUT2[23:16], bus.MEM_DOUT2[31:24]};
  assign w_wr_word = {bus.RX_DATA[7:0], bus.RX_DATA[15:8],
                      bus.RX_DATA[23:16], bus.RX_DATA[31:24]};
`else
  assign w_rd_word = bus.MEM_DOUT2;
  assign w_wr_word = bus.RX_DATA;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= c_st_idle;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rx_ready  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.START) begin
            r_src_ptr   <= bus.SRC_ADDR;
            r_dst_ptr   <= bus.DST_ADDR;
            r_remaining <= bus.LEN;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
            r_state     <= c_st_check;
          end
        end
        c_st_check: begin
          if (w_misaligned || w_out_of_range) begin
            r_error <= 1'b1;
            r_state <= c_st_finish;
          end else if (r_remaining == '0) begin
            r_state <= c_st_finish;
          end else begin
            r_mem_addr <= r_src_ptr;
            r_mem_read <= 1'b1;
            r_state    <= c_st_rd_req;
          end
        end
        c_st_rd_req: begin
          r_state <= c_st_rd_wait;
        end
        c_st_rd_wait: begin
          r_tx_data  <= w_rd_word;
          r_tx_valid <= 1'b1;
          r_state    <= c_st_send;
        end
        c_st_send: begin
          if (r_tx_valid && bus.TX_READY) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= c_st_recv;
          end
        end
        c_st_recv: begin
          if (bus.RX_VALID && r_rx_ready) begin
            r_mem_din   <= w_wr_word;
            r_rx_ready  <= 1'b0;
            r_mem_addr  <= r_dst_ptr;
            r_mem_write <= 1'b1;
            r_state     <= c_st_wr;
          end
        end
        c_st_wr: begin
          r_src_ptr   <= r_src_ptr + ADDR_W'(4);
          r_dst_ptr   <= r_dst_ptr + ADDR_W'(4);
          r_remaining <= r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            r_state <= c_st_finish;
          end else begin
            // Next read is issued straight from WR so words stay 5 cycles apart
            r_mem_addr <= r_src_ptr + ADDR_W'(4);
            r_mem_read <= 1'b1;
            r_state    <= c_st_rd_req;
          end
        end
        c_st_finish: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.ERROR      = r_error;
  assign bus.MEM_ADDR2  = r_mem_addr;
  assign bus.MEM_DIN2   = r_mem_din;
  assign bus.MEM_READ2  = r_mem_read;
  assign bus.MEM_WRITE2 = r_mem_write;
  assign bus.MEM_SIZE   = 2'd2;
  assign bus.MEM_SIGN   = 1'b0;
  assign bus.TX_DATA    = r_tx_data;
  assign bus.TX_VALID   = r_tx_valid;
  assign bus.RX_READY   = r_rx_ready;

endmodule
`default_nettype wire

// File: tb/tb_crypto_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crypto_mem_initiator
//  Purpose  : Directed bench for crypto_mem_initiator with a memory model and
//             an inverting cipher-core model with configurable stalls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crypto_mem_initiator;

  localparam logic [31:0] c_sent = 32'hDEAD_BEEF;
`ifdef CRYPTO_MEM_BSWAP_EN
  localparam logic [31:0] c_exp_tx0 = 32'h4433_2211;
`else
  localparam logic [31:0] c_exp_tx0 = 32'h1122_3344;
`endif

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          stall;
    int          delay;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crypto_mem_initiator_if #(.ADDR_W(32), .LEN_W(16)) bus ();
  crypto_mem_initiator dut (.CLK(clk), .RST(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data appears the cycle after MEM_READ2
  logic [31:0] mem [0:16383];
  logic        pk_en = 1'b0;
  logic [31:0] pk_a  = '0;
  logic [31:0] pk_d  = '0;
  always @(posedge clk) begin
    if (pk_en) mem[pk_a[15:2]] <= pk_d;
    if (bus.MEM_WRITE2 && bus.MEM_ADDR2 < 32'h1_0000) mem[bus.MEM_ADDR2[15:2]] <= bus.MEM_DIN2;
    if (bus.MEM_READ2 && bus.MEM_ADDR2 < 32'h1_0000) bus.MEM_DOUT2 <= mem[bus.MEM_ADDR2[15:2]];
  end

  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, ovl_cnt = 0;
  always @(negedge clk) begin
    if (bus.MEM_READ2) rd_cnt <= rd_cnt + 1;
    if (bus.MEM_WRITE2) wr_cnt <= wr_cnt + 1;
    if (bus.DONE) done_cnt <= done_cnt + 1;
    if (bus.MEM_READ2 && bus.MEM_WRITE2) ovl_cnt <= ovl_cnt + 1;
  end

  // Core model: result = input XOR all-ones
  int          cfg_stall = 0;
  int          cfg_delay = 0;
  int          tx_cnt    = 0;
  int          stall_bad = 0;
  logic [31:0] tx_hist [0:255];
  initial begin : core
    int          wcnt;
    int          rcnt;
    bit          pending;
    logic [31:0] held;
    logic [31:0] got;
    wcnt = 0; rcnt = 0; pending = 0; held = '0; got = '0;
    bus.TX_READY = 1'b0;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = '0;
    forever begin
      @(negedge clk);
      if (bus.TX_VALID) begin
        if (wcnt == 0) held = bus.TX_DATA;
        else if (bus.TX_DATA !== held) stall_bad = stall_bad + 1;
        if (wcnt < cfg_stall) begin
          bus.TX_READY = 1'b0;
          wcnt = wcnt + 1;
        end else begin
          bus.TX_READY = 1'b1;
          got = bus.TX_DATA;
          pending = 1;
          rcnt = 0;
          tx_hist[8'(tx_cnt)] = got;
          tx_cnt = tx_cnt + 1;
        end
      end else begin
        bus.TX_READY = 1'b0;
        wcnt = 0;
      end
      if (bus.RX_READY && pending) begin
        if (rcnt < cfg_delay) begin
          bus.RX_VALID = 1'b0;
          rcnt = rcnt + 1;
        end else begin
          bus.RX_VALID = 1'b1;
          bus.RX_DATA  = got ^ 32'hFFFF_FFFF;
          pending = 0;
        end
      end else begin
        bus.RX_VALID = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pk_a = a; pk_d = d; pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    bus.SRC_ADDR = s; bus.DST_ADDR = d; bus.LEN = l; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // Waits (bounded) for DONE; latency counts edges from the accepting edge
  task automatic wait_done(input int c0, output int lat, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (bus.DONE) begin tmo = 1'b0; break; end
      @(negedge clk);
    end
    lat = cyc - (c0 + 1);
  endtask

  vec_t        vt [0:7];
  logic [31:0] src_pat [0:3];
  logic [31:0] exp_w   [0:3];

  function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                              input int st, input int dl, input logic e, input int lat);
    vec_t v;
    v.src = s; v.dst = d; v.len = l; v.stall = st; v.delay = dl; v.exp_err = e; v.exp_lat = lat;
    return v;
  endfunction

  initial begin : main
    int          c0, lat, rd0, wr0, dn0, ov0, sb0, tx0, nw;
    bit          tmo, found;
    logic [31:0] a;
    logic [31:0] base_s, base_d;

    src_pat[0] = 32'h1122_3344; src_pat[1] = 32'h5566_7788;
    src_pat[2] = 32'h99AA_BBCC; src_pat[3] = 32'hDDEE_FF00;
    exp_w[0]   = 32'hEEDD_CCBB; exp_w[1]   = 32'hAA99_8877;
    exp_w[2]   = 32'h6655_4433; exp_w[3]   = 32'h2211_00FF;

    vt[0] = mk(32'h0100, 32'h0200, 16'd4, 0, 0, 1'b0, 22);
    vt[1] = mk(32'h0100, 32'h0200, 16'd4, 3, 5, 1'b0, 54);
    vt[2] = mk(32'h0102, 32'h0200, 16'd1, 0, 0, 1'b1, 2);
    vt[3] = mk(32'hFFFC, 32'h0200, 16'd2, 0, 0, 1'b1, 2);
    vt[4] = mk(32'h0100, 32'h0200, 16'd0, 0, 0, 1'b0, 2);
    vt[5] = mk(32'h0100, 32'h0201, 16'd1, 0, 0, 1'b1, 2);
    vt[6] = mk(32'hFFF8, 32'hFFFC, 16'd1, 0, 0, 1'b0, 7);
    vt[7] = mk(32'h0100, 32'hFFFC, 16'd2, 0, 0, 1'b1, 2);

    bus.START = 1'b0; bus.SRC_ADDR = '0; bus.DST_ADDR = '0; bus.LEN = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",     32'(bus.BUSY), 32'd0);
    chk("rst_done",     32'(bus.DONE), 32'd0);
    chk("rst_error",    32'(bus.ERROR), 32'd0);
    chk("rst_strobes",  {30'd0, bus.MEM_READ2, bus.MEM_WRITE2}, 32'd0);
    chk("rst_handshk",  {30'd0, bus.TX_VALID, bus.RX_READY}, 32'd0);
    chk("rst_addr",     bus.MEM_ADDR2, 32'd0);
    chk("rst_din",      bus.MEM_DIN2, 32'd0);
    chk("rst_txdata",   bus.TX_DATA, 32'd0);
    chk("mem_size",     32'(bus.MEM_SIZE), 32'd2);
    chk("mem_sign",     32'(bus.MEM_SIGN), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cfg_stall = vt[i].stall;
      cfg_delay = vt[i].delay;
      base_s = vt[i].src & 32'hFFFF_FFFC;
      base_d = vt[i].dst & 32'hFFFF_FFFC;
      for (int k = 0; k < 4; k++) begin
        a = base_s + 32'(4 * k);
        if (a < 32'h1_0000) poke(a, src_pat[k]);
      end
      for (int k = 0; k < 4; k++) begin
        a = base_d + 32'(4 * k);
        if (a < 32'h1_0000) poke(a, c_sent);
      end
      rd0 = rd_cnt; wr0 = wr_cnt; ov0 = ovl_cnt; sb0 = stall_bad; tx0 = tx_cnt;
      @(negedge clk);
      bus.SRC_ADDR = vt[i].src; bus.DST_ADDR = vt[i].dst; bus.LEN = vt[i].len; bus.START = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus.START = 1'b0;
      chk($sformatf("v%0d_busy_on", i), 32'(bus.BUSY), 32'd1);
      wait_done(c0, lat, tmo);
      chk($sformatf("v%0d_done_timeout", i), 32'(tmo), 32'd0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_error", i), 32'(bus.ERROR), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_busy_off", i), 32'(bus.BUSY), 32'd0);
      nw = (vt[i].exp_err == 1'b0) ? int'(vt[i].len) : 0;
      chk($sformatf("v%0d_reads", i), 32'(rd_cnt - rd0), 32'(nw));
      chk($sformatf("v%0d_writes", i), 32'(wr_cnt - wr0), 32'(nw));
      chk($sformatf("v%0d_overlap", i), 32'(ovl_cnt - ov0), 32'd0);
      chk($sformatf("v%0d_tx_stable", i), 32'(stall_bad - sb0), 32'd0);
      for (int k = 0; k < 4; k++) begin
        a = base_d + 32'(4 * k);
        if (a < 32'h1_0000)
          chk($sformatf("v%0d_dst%0d", i, k), mem[a[15:2]], (k < nw) ? exp_w[k] : c_sent);
      end
      if (i == 0) chk("v0_tx_word0", tx_hist[8'(tx0)], c_exp_tx0);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), 32'(bus.DONE), 32'd0);
    end

    // In-place transfer with an ignored second START
    cfg_stall = 0; cfg_delay = 0;
    poke(32'h0300, 32'hA5A5_A5A5);
    poke(32'h0304, 32'h0F0F_0F0F);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge clk);
    bus.SRC_ADDR = 32'h0300; bus.DST_ADDR = 32'h0300; bus.LEN = 16'd2; bus.START = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (4) @(negedge clk);
    bus.SRC_ADDR = 32'h0100; bus.DST_ADDR = 32'h0500; bus.LEN = 16'd1; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(c0, lat, tmo);
    chk("inpl_done_timeout", 32'(tmo), 32'd0);
    chk("inpl_latency", 32'(lat), 32'd12);
    repeat (15) @(negedge clk);
    chk("inpl_done_count", 32'(done_cnt - dn0), 32'd1);
    chk("inpl_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("inpl_writes", 32'(wr_cnt - wr0), 32'd2);
    chk("inpl_word0", mem[32'h0300 >> 2], 32'h5A5A_5A5A);
    chk("inpl_word1", mem[32'h0304 >> 2], 32'hF0F0_F0F0);
    chk("inpl_busy", 32'(bus.BUSY), 32'd0);

    // Reset while word 2 of 4 sits in SEND
    cfg_stall = 3; cfg_delay = 0;
    for (int k = 0; k < 4; k++) poke(32'h0100 + 32'(4 * k), src_pat[k]);
    for (int k = 0; k < 4; k++) poke(32'h0400 + 32'(4 * k), c_sent);
    wr0 = wr_cnt; dn0 = done_cnt;
    pulse_start(32'h0100, 32'h0400, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((wr_cnt - wr0) == 1 && bus.TX_VALID) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_mid_reached_send", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_mid_txvalid", 32'(bus.TX_VALID), 32'd0);
    chk("rst_mid_strobes", {30'd0, bus.MEM_READ2, bus.MEM_WRITE2}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt - dn0), 32'd0);
    chk("rst_mid_word1", mem[32'h0400 >> 2], 32'hEEDD_CCBB);
    chk("rst_mid_word2", mem[32'h0404 >> 2], c_sent);
    chk("rst_mid_word3", mem[32'h0408 >> 2], c_sent);
    chk("rst_mid_word4", mem[32'h040C >> 2], c_sent);

    cfg_stall = 0;
    @(negedge clk);
    bus.SRC_ADDR = 32'h0100; bus.DST_ADDR = 32'h0400; bus.LEN = 16'd4; bus.START = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(c0, lat, tmo);
    chk("after_rst_timeout", 32'(tmo), 32'd0);
    chk("after_rst_latency", 32'(lat), 32'd22);
    chk("after_rst_error", 32'(bus.ERROR), 32'd0);
    @(negedge clk);
    chk("after_rst_word2", mem[32'h0404 >> 2], 32'hAA99_8877);
    chk("after_rst_word4", mem[32'h040C >> 2], 32'h2211_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
